// File: rtl/snn_ctrl.sv
// Sequencer for the SNN classifier. It loads one binary image from the UART into the
// image RAM, runs the core, and reports the digit on the LEDs and back over the UART.
module snn_ctrl #(
  parameter int unsigned NUM_BYTES   = 98,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned TIMEOUT_CYC = 52080,
  parameter int unsigned TO_W        = 16
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  input  logic              tx_rdy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [7:0]        led
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_TX    = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              core_start_q, core_start_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic [3:0]        digit_q, digit_d;
  logic              err_q, err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    core_start_d = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    busy_d       = 1'b0;
    digit_d      = digit_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (rx_rdy) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = '0;
          ram_wdata_d = rx_data;
          cnt_d       = ADDR_W'(1);
          to_d        = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        // A byte arriving in the terminal-count cycle takes priority over the timeout.
        if (rx_rdy) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = cnt_q;
          ram_wdata_d = rx_data;
          to_d        = '0;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (to_q == TO_LAST) begin
          to_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_START: begin
        core_start_d = 1'b1;
        busy_d       = 1'b1;
        if (rx_rdy) err_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy_d = 1'b1;
        if (rx_rdy) err_d = 1'b1;
        if (core_done) begin
          digit_d = core_digit;
          if (core_digit <= 4'd9) begin
            tx_data_d = 8'h30 + {4'h0, core_digit};
          end else begin
            tx_data_d = 8'h3F;
            err_d     = 1'b1;
          end
          state_d = S_TX;
        end
      end
      S_TX: begin
        busy_d = 1'b1;
        if (rx_rdy) err_d = 1'b1;
        if (tx_rdy) begin
          tx_start_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      to_q         <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      core_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      digit_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      core_start_q <= core_start_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      digit_q      <= digit_d;
      err_q        <= err_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign core_start = core_start_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign led        = {err_q, 3'b000, digit_q};

endmodule

// File: doc/snn_ctrl.md
Name: snn_ctrl

Overview:
Top-level sequencer for the SNN classifier. It collects one 784-pixel binary image from the UART receiver as 98 bytes and writes them into the input image RAM. It then starts the SNN core, waits for the classified digit, shows the digit on the LEDs and returns it over the UART transmitter as ASCII. It sits between uart_rx/uart_tx, the image RAM and the SNN core inside the snn top level.

Parameters:
NUM_BYTES, 98, bytes per image (784 pixels / 8)
ADDR_W, 7, image RAM address width
TIMEOUT_CYC, 52080, maximum idle cycles between bytes inside one image (20 bit-times at 2604 clk/bit)
TO_W, 16, width of the timeout counter

Ports:
clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
rx_rdy  in  1  one-cycle pulse: rx_data holds a new received byte
rx_data  in  8  received byte
ram_we  out  1  image RAM write enable
ram_addr  out  ADDR_W  image RAM write address
ram_wdata  out  8  image RAM write data
core_start  out  1  one-cycle pulse that starts SNN inference
core_done  in  1  one-cycle pulse: core_digit is valid
core_digit  in  4  classified digit
tx_rdy  in  1  transmitter idle and able to accept a byte
tx_start  out  1  one-cycle pulse: load tx_data into the transmitter
tx_data  out  8  byte to transmit
busy  out  1  high from START through the end of TX
led  out  8  {err, 3'b000, last digit}

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state=IDLE, byte count=0, timeout count=0.
  - ram_we, core_start, tx_start, busy = 0; ram_addr, ram_wdata, tx_data, led = 0.
  - Reset asserted mid-operation aborts immediately; a partial image is discarded.
- States: IDLE, LOAD, START, WAIT_CORE, TX.
- IDLE:
  - On rx_rdy: next cycle ram_we=1, ram_addr=0, ram_wdata=rx_data; count=1; go to LOAD.
  - No timeout runs in IDLE.
- LOAD:
  - Each rx_rdy writes the byte next cycle (1-cycle latency) at ram_addr=count, then count increments.
  - The write of byte NUM_BYTES-1 moves the FSM to START.
  - Timeout counter clears on every rx_rdy and increments otherwise.
  - When it reaches TIMEOUT_CYC-1 without a byte: go to IDLE, count=0, set err. No core_start.
  - rx_rdy in the terminal-count cycle: the byte wins and no timeout occurs.
- START:
  - core_start=1 for exactly one cycle, i.e. the cycle after the last ram_we.
  - Go to WAIT_CORE. busy=1 from START until the tx_start cycle inclusive.
- WAIT_CORE:
  - Waits indefinitely for core_done.
  - On core_done: led[3:0]=core_digit.
  - tx_data = 8'h30 + core_digit if core_digit <= 9.
  - Otherwise tx_data = 8'h3F ('?'), led[3:0]=core_digit, and err is set.
  - Go to TX.
- TX:
  - On the first cycle with tx_rdy=1: tx_start=1 for one cycle, tx_data held stable.
  - Go to IDLE.
  - tx_data holds its value until the next core_done.
- Overrun: rx_rdy received in START, WAIT_CORE or TX is dropped (no ram_we) and sets err.
- err (led[7]) is sticky and is cleared only by reset. led[6:4]=0 always.
- rx_rdy and core_done in the same cycle: core_done is processed and the byte is dropped as an overrun.
- ram_we is only ever a 1-cycle pulse. ram_addr never exceeds NUM_BYTES-1. The count wraps to 0 for every new image.
- A spurious core_done outside WAIT_CORE is ignored.

Test Plan:
- Send 98 bytes (0xA5, then 0x93 repeated), 1 cycle apart:
  - 98 ram_we pulses at addr 0..97 with matching data.
  - core_start high for exactly one cycle, the cycle after the addr-97 write.
  - busy rises with it.
- After the load, core_done with core_digit=7 and tx_rdy=1:
  - led=8'h07.
  - tx_start for one cycle with tx_data=8'h37.
  - busy drops after that cycle; FSM back in IDLE.
- Send 40 bytes, then stay silent for TIMEOUT_CYC cycles:
  - no core_start; led[7]=1.
  - A following full 98-byte image writes again from addr 0 and completes normally.
- core_digit=12 on core_done:
  - tx_data=8'h3F, led=8'h8C.
- Bytes arrive while in WAIT_CORE:
  - no ram_we; led[7]=1.
- tx_rdy held low for 100 cycles after core_done:
  - tx_start waits and fires on the first cycle tx_rdy=1.
- Assert sys_rst for one cycle after byte 50:
  - all outputs 0, led=0.
  - The next image starts writing at addr 0.
